corr_peak_detector: RTL
=======================

# corr_peak_detector

- Downstream consumer of the cross-correlator's five lag outputs.
- Accepts one vector of five lag scores per valid/ready transfer and finds the peak lag, with lowest index winning ties.
- Runs a search/verify/lock state machine that declares alignment once the same lag wins repeatedly.
- Presents each result on a registered valid/ready output port.

## Interface

Parameters:
- LAG_W, 2: width of each lag score, unsigned.
- THRESH, 2: minimum peak score that counts as a qualifying peak, 1..2^LAG_W-1.
- CONFIRM, 3: consecutive qualifying peaks at the same lag needed to lock, ≥1.
- MISS_MAX, 2: consecutive non-matching vectors while locked before lock is dropped, ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  lag vector present.
- in_ready  out  1  block can accept a vector; equals !rst && (!out_valid || out_ready).
- lag0..lag4  in  LAG_W each  lag scores. Index 2 is zero shift, 0/1 are in2-leading, 3/4 are in1-leading.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result.
- peak_lag  out  3  argmax index 0..4.
- peak_val  out  LAG_W  score at peak_lag.
- peak_qual  out  1  peak_val ≥ THRESH.
- locked  out  1  FSM is in LOCKED.
- lock_lag  out  3  lag held while locked; 0 otherwise.
- fsm_state  out  2  SEARCH=0, VERIFY=1, LOCKED=2.

## Operation

- Accept: a transfer occurs on any cycle with in_valid && in_ready. The FSM advances only on accepted vectors.
- Argmax:
  - Compare all five scores unsigned; the highest wins.
  - On a tie, the lowest index wins.
  - An all-zero vector gives peak_lag=0, peak_val=0, and peak_qual=0 whenever THRESH ≥ 1.
- Counters: cnt is ceil(log2(CONFIRM+1)) bits; miss is ceil(log2(MISS_MAX+1)) bits. Neither counter wraps.
- FSM (q = qualifying peak, L = its lag):
  - SEARCH:
    - q → VERIFY, cand=L, cnt=1.
    - If CONFIRM=1, q goes directly to LOCKED instead.
  - VERIFY:
    - q and L==cand → cnt+1. Reaching CONFIRM → LOCKED, lock_lag=cand, miss=0.
    - q and L≠cand → stay in VERIFY, cand=L, cnt=1.
    - !q → SEARCH, cnt=0.
  - LOCKED:
    - q and L==lock_lag → miss=0.
    - Otherwise miss+1. Reaching MISS_MAX → SEARCH, locked=0, lock_lag=0, miss=0.
    - A qualifying peak at another lag counts as a miss and never re-targets directly.
- Illegal fsm_state encoding (3) → SEARCH on the next accepted vector.
- Reset:
  - out_valid, peak_lag, peak_val, peak_qual, locked, lock_lag, fsm_state, cnt, miss and cand all go to 0.
  - in_ready is 0 while rst is high.
  - Asserting rst in the middle of a lock drops the lock on that edge. A result held but not yet consumed is discarded.

## Timing

- Latency is 1 cycle. For a vector accepted at edge N, the peak fields, locked, lock_lag and fsm_state all reflect it from edge N onward, and out_valid=1.
- locked rises on the same edge that accepts the CONFIRM-th matching vector. It falls on the edge that accepts the MISS_MAX-th miss.
- Output hold: out_valid && !out_ready holds every output field stable and forces in_ready=0.
- Simultaneous consume and accept: when out_valid && out_ready && in_valid are all true in one cycle, a new result loads and out_valid stays 1. This sustains full throughput of one vector per cycle.
- Consume only: out_ready with no accept clears out_valid. Status outputs keep their values.
- in_ready must not depend combinationally on in_valid.

## Configuration

- CORR_PEAK_STATS_EN defined:
  - Adds outputs vec_count[15:0] and lock_loss_count[7:0].
  - vec_count counts accepted vectors.
  - lock_loss_count counts LOCKED→SEARCH transitions caused by misses.
  - Both saturate at all-ones, clear on rst, and update on the same edge as the FSM.
- CORR_PEAK_STATS_EN undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan

All scenarios use default parameters.
1. Reset then idle → all outputs 0 and in_ready=0 during rst. in_ready=1 on the first cycle after rst, with out_ready=1.
2. Tie-break: accept lags {1,3,3,0,2} → peak_lag=1, peak_val=3, peak_qual=1, fsm_state=1.
3. Lock: accept 3 consecutive vectors peaking at lag 2 with score 2 → locked rises on the third accept edge, lock_lag=2, fsm_state=2. A VERIFY interruption at lag 4 resets cnt to 1, so lock requires 3 more matches.
4. Lock loss: from LOCKED on lag 2, accept an all-zero vector, then a vector peaking at lag 2, then two vectors peaking at lag 3 → lock is held through the first three accepts and dropped on the fourth. With the stats macro defined, lock_loss_count=1.
5. Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 → in_ready=0 and outputs frozen. Then set out_ready=1 → one vector per cycle flows with no drops or duplicates.
6. Assert rst for one cycle while locked with a result held → next cycle locked=0, out_valid=0, fsm_state=0.

Source files
------------

// File: rtl/corr_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : corr_peak_detector
// Description : Argmax over five correlator lag scores with a search/verify/
//               lock alignment FSM behind a registered valid/ready output.
//               Define CORR_PEAK_STATS_EN to add vector and lock-loss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module corr_peak_detector #(
    parameter int LAG_W    = 2,
    parameter int THRESH   = 2,
    parameter int CONFIRM  = 3,
    parameter int MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LAG_W-1:0] lag0,
    input  logic [LAG_W-1:0] lag1,
    input  logic [LAG_W-1:0] lag2,
    input  logic [LAG_W-1:0] lag3,
    input  logic [LAG_W-1:0] lag4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       peak_lag,
    output logic [LAG_W-1:0] peak_val,
    output logic             peak_qual,
    output logic             locked,
    output logic [2:0]       lock_lag,
    output logic [1:0]       fsm_state
`ifdef CORR_PEAK_STATS_EN
    ,
    output logic [15:0]      vec_count,
    output logic [7:0]       lock_loss_count
`endif
);

    localparam int CNT_W  = $clog2(CONFIRM + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [1:0] c_SEARCH = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam logic [LAG_W-1:0]  c_thresh       = LAG_W'(THRESH);
    localparam logic [CNT_W-1:0]  c_confirm_last = CNT_W'(CONFIRM - 1);
    localparam logic [MISS_W-1:0] c_miss_last    = MISS_W'(MISS_MAX - 1);

    logic [1:0]        r_state;
    logic [2:0]        r_cand;
    logic [CNT_W-1:0]  r_cnt;
    logic [MISS_W-1:0] r_miss;
    logic [2:0]        r_lock_lag;
    logic              r_out_valid;
    logic [2:0]        r_peak_lag;
    logic [LAG_W-1:0]  r_peak_val;
    logic              r_peak_qual;

    logic [LAG_W-1:0]  w_lags [5];
    logic [2:0]        w_peak_lag;
    logic [LAG_W-1:0]  w_peak_val;
    logic              w_qual;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_lock_hit;
    logic              w_lock_loss;

    assign w_lags[0] = lag0;
    assign w_lags[1] = lag1;
    assign w_lags[2] = lag2;
    assign w_lags[3] = lag3;
    assign w_lags[4] = lag4;

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_peak_lag = 3'd0;
        w_peak_val = w_lags[0];
        for (int i = 1; i < 5; i++) begin
            if (w_lags[i] > w_peak_val) begin
                w_peak_val = w_lags[i];
                w_peak_lag = 3'(i);
            end
        end
    end

    assign w_qual      = (w_peak_val >= c_thresh);
    assign w_in_ready  = !rst && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_lock_hit  = w_qual && (w_peak_lag == r_lock_lag);
    assign w_lock_loss = (r_state == c_LOCKED) && !w_lock_hit && (r_miss == c_miss_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_SEARCH;
            r_cand      <= 3'd0;
            r_cnt       <= '0;
            r_miss      <= '0;
            r_lock_lag  <= 3'd0;
            r_out_valid <= 1'b0;
            r_peak_lag  <= 3'd0;
            r_peak_val  <= '0;
            r_peak_qual <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_peak_lag  <= w_peak_lag;
            r_peak_val  <= w_peak_val;
            r_peak_qual <= w_qual;
            case (r_state)
                c_SEARCH: begin
                    if (w_qual) begin
                        if (CONFIRM == 1) begin
                            r_state    <= c_LOCKED;
                            r_lock_lag <= w_peak_lag;
                            r_miss     <= '0;
                            r_cnt      <= '0;
                        end else begin
                            r_state <= c_VERIFY;
                            r_cand  <= w_peak_lag;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                c_VERIFY: begin
                    if (!w_qual) begin
                        r_state <= c_SEARCH;
                        r_cnt   <= '0;
                    end else if (w_peak_lag != r_cand) begin
                        r_cand <= w_peak_lag;
                        r_cnt  <= CNT_W'(1);
                    end else if (r_cnt == c_confirm_last) begin
                        r_state    <= c_LOCKED;
                        r_lock_lag <= r_cand;
                        r_miss     <= '0;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_LOCKED: begin
                    if (w_lock_hit) begin
                        r_miss <= '0;
                    end else if (w_lock_loss) begin
                        r_state    <= c_SEARCH;
                        r_lock_lag <= 3'd0;
                        r_miss     <= '0;
                    end else begin
                        r_miss <= r_miss + MISS_W'(1);
                    end
                end
                default: begin
                    r_state    <= c_SEARCH;
                    r_cnt      <= '0;
                    r_miss     <= '0;
                    r_lock_lag <= 3'd0;
                end
            endcase
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef CORR_PEAK_STATS_EN
    logic [15:0] r_vec_count;
    logic [7:0]  r_lock_loss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_count       <= '0;
            r_lock_loss_count <= '0;
        end else if (w_accept) begin
            if (r_vec_count != 16'hFFFF) begin
                r_vec_count <= r_vec_count + 16'd1;
            end
            if (w_lock_loss && (r_lock_loss_count != 8'hFF)) begin
                r_lock_loss_count <= r_lock_loss_count + 8'd1;
            end
        end
    end

    assign vec_count       = r_vec_count;
    assign lock_loss_count = r_lock_loss_count;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign peak_lag  = r_peak_lag;
    assign peak_val  = r_peak_val;
    assign peak_qual = r_peak_qual;
    assign locked    = (r_state == c_LOCKED);
    assign lock_lag  = r_lock_lag;
    assign fsm_state = r_state;

endmodule
`default_nettype wire
